// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter.
//   wb_arb_entry_t : one long-latency result as held in the FIFO (default widths)
//   wb_arb_state_e : starvation FSM states
// Optional feature macro used by the top: WB_ARB_BYPASS_EN.
package wb_port_arbiter_pkg;

    localparam int WB_ARB_DWIDTH = 32;
    localparam int WB_ARB_RWIDTH = 5;

    typedef struct packed {
        logic                     live;
        logic [WB_ARB_RWIDTH-1:0] rd;
        logic [WB_ARB_DWIDTH-1:0] data;
    } wb_arb_entry_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_STALL = 2'd2
    } wb_arb_state_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular buffer for long-latency results with per-entry kill-by-rd.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_push/_rd/_data    enqueue (ignored when full)
//   i_pop               drop head (ignored when empty)
//   i_kill/_rd          clear live bit of every entry targeting _rd
//   o_count/full/empty  occupancy
//   o_head_*            head entry
//   o_pending           bit r set when a live entry targets r
module wb_arb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DWIDTH = WB_ARB_DWIDTH,
    parameter int RWIDTH = WB_ARB_RWIDTH,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [RWIDTH-1:0]        i_push_rd,
    input  logic [DWIDTH-1:0]        i_push_data,
    input  logic                     i_pop,
    input  logic                     i_kill,
    input  logic [RWIDTH-1:0]        i_kill_rd,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_head_live,
    output logic [RWIDTH-1:0]        o_head_rd,
    output logic [DWIDTH-1:0]        o_head_data,
    output logic [2**RWIDTH-1:0]     o_pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  r_live;
    logic [RWIDTH-1:0] r_rd   [DEPTH];
    logic [DWIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;

    logic w_push, w_pop, w_push_live;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // x0 entries are never live, so live alone means "must write".
    // A same-edge pipe write to the same rd is younger and kills it on entry.
    assign w_push_live = (i_push_rd != '0) && !(i_kill && (i_kill_rd == i_push_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Popped slots are cleared, so free slots never contribute to o_pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wptr == PW'(i)))
                    r_live[i] <= w_push_live;
                else if ((w_pop && (r_rptr == PW'(i))) || (i_kill && (r_rd[i] == i_kill_rd)))
                    r_live[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= i_push_rd;
            r_data[r_wptr] <= i_push_data;
        end
    end

    assign o_head_live = r_live[r_rptr];
    assign o_head_rd   = r_rd[r_rptr];
    assign o_head_data = r_data[r_rptr];

    always_comb begin
        o_pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_live[i]) o_pending[r_rd[i]] = 1'b1;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: the pipeline writeback always wins; long-latency
// results queue in wb_arb_fifo and drain into idle slots. A pipe write kills older
// queued results to the same register (WAW). A head that waits too long raises
// stall_req_o until it gets a slot.
// Optional: define WB_ARB_BYPASS_EN to write an lu result straight through when the
// FIFO is empty and the slot is idle.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   pipe_we_i/pipe_rd_i/pipe_data_i     pipeline writeback
//   lu_valid_i/lu_rd_i/lu_data_i        long-latency result, lu_ready_o handshake
//   rf_we_o/rf_rd_o/rf_data_o           register-file write port
//   pending_o                           live queued destinations (hazard unit)
//   stall_req_o                         starvation stall request
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DWIDTH       = 32,
    parameter int RWIDTH       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_we_i,
    input  logic [RWIDTH-1:0]    pipe_rd_i,
    input  logic [DWIDTH-1:0]    pipe_data_i,
    input  logic                 lu_valid_i,
    input  logic [RWIDTH-1:0]    lu_rd_i,
    input  logic [DWIDTH-1:0]    lu_data_i,
    output logic                 lu_ready_o,
    output logic                 rf_we_o,
    output logic [RWIDTH-1:0]    rf_rd_o,
    output logic [DWIDTH-1:0]    rf_data_o,
    output logic [2**RWIDTH-1:0] pending_o,
    output logic                 stall_req_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STARVE_LIMIT+1);

    logic          r_alive;
    wb_arb_state_e r_state;
    logic [SW-1:0] r_wcnt;

    logic              w_pipe_wr, w_pop, w_push, w_bypass, w_drain;
    logic              w_full, w_empty, w_head_live;
    logic [CW-1:0]     w_count;
    logic [RWIDTH-1:0] w_head_rd;
    logic [DWIDTH-1:0] w_head_data;

    // Low through reset and until the first edge after release, so every
    // output (lu_ready_o included) reads 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_alive <= 1'b0;
        else        r_alive <= 1'b1;
    end

    assign w_pipe_wr  = r_alive && pipe_we_i && (pipe_rd_i != '0);
    assign w_pop      = r_alive && !w_pipe_wr && !w_empty;
    assign lu_ready_o = r_alive && !w_full;

`ifdef WB_ARB_BYPASS_EN
    assign w_bypass = r_alive && w_empty && !w_pipe_wr && lu_valid_i && (lu_rd_i != '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = lu_valid_i && lu_ready_o && !w_bypass;

    wb_arb_fifo #(
        .DWIDTH (DWIDTH),
        .RWIDTH (RWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_rd   (lu_rd_i),
        .i_push_data (lu_data_i),
        .i_pop       (w_pop),
        .i_kill      (w_pipe_wr),
        .i_kill_rd   (pipe_rd_i),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_live (w_head_live),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_pending   (pending_o)
    );

    // A live head always has rd != 0, so head_live is the whole write condition.
    always_comb begin
        rf_we_o   = 1'b0;
        rf_rd_o   = '0;
        rf_data_o = '0;
        if (w_pipe_wr) begin
            rf_we_o   = 1'b1;
            rf_rd_o   = pipe_rd_i;
            rf_data_o = pipe_data_i;
        end else if (w_pop) begin
            if (w_head_live) begin
                rf_we_o   = 1'b1;
                rf_rd_o   = w_head_rd;
                rf_data_o = w_head_data;
            end
        end else if (w_bypass) begin
            rf_we_o   = 1'b1;
            rf_rd_o   = lu_rd_i;
            rf_data_o = lu_data_i;
        end
    end

    // FIFO goes empty at this edge: last entry leaves and nothing arrives.
    assign w_drain = w_pop && !w_push && (w_count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_push) r_state <= ARB_WAIT;
                    r_wcnt <= '0;
                end
                ARB_WAIT: begin
                    if (w_drain) begin
                        r_state <= ARB_IDLE;
                        r_wcnt  <= '0;
                    end else if (w_pop) begin
                        r_wcnt <= '0;
                    end else if (r_wcnt == SW'(STARVE_LIMIT-1)) begin
                        r_state <= ARB_STALL;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + SW'(1);
                    end
                end
                ARB_STALL: begin
                    if (w_pop) begin
                        r_state <= w_drain ? ARB_IDLE : ARB_WAIT;
                        r_wcnt  <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    assign stall_req_o = (r_state == ARB_STALL);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_rd_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        lu_valid_i = 1'b0;
    logic [4:0]  lu_rd_i = '0;
    logic [31:0] lu_data_i = '0;
    logic        lu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;
    logic [31:0] pending_o;
    logic        stall_req_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] rf_m [32] = '{default: '0};

    wb_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we_i   (pipe_we_i),
        .pipe_rd_i   (pipe_rd_i),
        .pipe_data_i (pipe_data_i),
        .lu_valid_i  (lu_valid_i),
        .lu_rd_i     (lu_rd_i),
        .lu_data_i   (lu_data_i),
        .lu_ready_o  (lu_ready_o),
        .rf_we_o     (rf_we_o),
        .rf_rd_o     (rf_rd_o),
        .rf_data_o   (rf_data_o),
        .pending_o   (pending_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    // Register file model: captures whatever the port writes.
    always @(posedge clk) if (rf_we_o) rf_m[rf_rd_o] <= rf_data_o;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_we_i = pw; pipe_rd_i = prd; pipe_data_i = pd;
        lu_valid_i = lv; lu_rd_i = lrd; lu_data_i = ld;
    endtask

    initial begin
        // reset: pipe write presented during reset must not reach the RF
        #2;
        drive(1, 3, 32'h77, 0, 0, 0);
        #1;
        chk("rst_we", rf_we_o, 0);
        chk("rst_ready", lu_ready_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_stall", stall_req_o, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", lu_ready_o, 1);

        // 1: single lu result, pipe idle
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
        #1;
`ifdef WB_ARB_BYPASS_EN
        chk("t1_byp_we", rf_we_o, 1);
        chk("t1_byp_rd", rf_rd_o, 5);
        chk("t1_byp_data", rf_data_o, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_byp_we_next", rf_we_o, 0);
        chk("t1_byp_pending", pending_o, 0);
`else
        chk("t1_we_same", rf_we_o, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_we", rf_we_o, 1);
        chk("t1_rd", rf_rd_o, 5);
        chk("t1_data", rf_data_o, 32'hDEADBEEF);
        chk("t1_pending", pending_o, 32'h20);
`endif
        tick();
        chk("t1_we_after", rf_we_o, 0);
        chk("t1_pending_after", pending_o, 0);
        chk("t1_rf5", rf_m[5], 32'hDEADBEEF);

        // 2: pipe busy on x1, fill FIFO with rd 2..5
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h100 + k, 1, 5'(k + 2), 32'h200 + k + 2);
            #1;
            chk("t2_ready", lu_ready_o, 1);
            chk("t2_pipe_rd", rf_rd_o, 1);
            tick();
        end
        drive(1, 1, 32'h104, 1, 6, 32'h206);
        #1;
        chk("t2_full_ready", lu_ready_o, 0);
        chk("t2_pending", pending_o, 32'h3C);
        chk("t2_stall", stall_req_o, 0);

        // 3: starvation - stall 8 cycles after first enqueue
        for (int k = 5; k <= 8; k++) begin
            tick();
            chk("t3_ready_held", lu_ready_o, 0);
            chk("t3_stall_pre", stall_req_o, 0);
        end
        tick();
        chk("t3_stall", stall_req_o, 1);
        chk("t3_pipe_prio_we", rf_we_o, 1);
        chk("t3_pipe_prio_rd", rf_rd_o, 1);
        tick();
        drive(0, 0, 0, 1, 6, 32'h206);
        #1;
        chk("t3_pop0_rd", rf_rd_o, 2);
        chk("t3_pop0_data", rf_data_o, 32'h202);
        chk("t3_pop0_stall", stall_req_o, 1);
        chk("t3_pop0_ready", lu_ready_o, 0);
        tick();
        chk("t3_stall_drop", stall_req_o, 0);
        chk("t3_ready_back", lu_ready_o, 1);
        chk("t3_pop1_rd", rf_rd_o, 3);
        chk("t3_pop1_data", rf_data_o, 32'h203);
        chk("t3_pending1", pending_o, 32'h38);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t3_pop2_rd", rf_rd_o, 4);
        chk("t3_pending2", pending_o, 32'h70);
        tick();
        chk("t3_pop3_rd", rf_rd_o, 5);
        tick();
        chk("t3_pop4_rd", rf_rd_o, 6);
        chk("t3_pop4_data", rf_data_o, 32'h206);
        tick();
        chk("t3_empty_we", rf_we_o, 0);
        chk("t3_empty_pending", pending_o, 0);
        chk("t3_empty_stall", stall_req_o, 0);
        chk("t3_rf2", rf_m[2], 32'h202);

        // 4: WAW kill of queued rd=7
        drive(1, 1, 32'h1, 1, 7, 32'h11);
        tick();
        drive(1, 7, 32'h22, 0, 0, 0);
        #1;
        chk("t4_pending7", pending_o, 32'h80);
        chk("t4_pipe_rd", rf_rd_o, 7);
        chk("t4_pipe_data", rf_data_o, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t4_killed_pending", pending_o, 0);
        chk("t4_killed_we", rf_we_o, 0);
        tick();
        chk("t4_rf7", rf_m[7], 32'h22);
        chk("t4_idle_we", rf_we_o, 0);
        // same-cycle enqueue to the register the pipe writes
        drive(1, 9, 32'h99, 1, 9, 32'h55);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t4b_pending", pending_o, 0);
        chk("t4b_we", rf_we_o, 0);
        tick();
        chk("t4b_rf9", rf_m[9], 32'h99);
        chk("t4b_idle_we", rf_we_o, 0);

        // 5: x0 results and pipe writes to x0
        drive(1, 1, 32'h5, 1, 0, 32'hAA);
        tick();
        drive(1, 1, 32'h6, 1, 8, 32'h88);
        tick();
        drive(1, 0, 32'h33, 0, 0, 0);
        #1;
        chk("t5_x0_we", rf_we_o, 0);
        chk("t5_pending", pending_o, 32'h100);
        tick();
        chk("t5_pop8_we", rf_we_o, 1);
        chk("t5_pop8_rd", rf_rd_o, 8);
        chk("t5_pop8_data", rf_data_o, 32'h88);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_done_we", rf_we_o, 0);
        chk("t5_done_pending", pending_o, 0);
        chk("t5_rf0", rf_m[0], 0);

        // 6: reset with 3 entries queued
        drive(1, 1, 32'h7, 1, 10, 32'hA0);
        tick();
        drive(1, 1, 32'h8, 1, 11, 32'hB0);
        tick();
        drive(1, 1, 32'h9, 1, 12, 32'hC0);
        tick();
        drive(1, 1, 32'hA, 0, 0, 0);
        #1;
        chk("t6_pending", pending_o, 32'h1C00);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", rf_we_o, 0);
        chk("t6_rst_pending", pending_o, 0);
        chk("t6_rst_ready", lu_ready_o, 0);
        chk("t6_rst_stall", stall_req_o, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_ready", lu_ready_o, 1);
        chk("t6_pending_after", pending_o, 0);
        for (int k = 0; k < 3; k++) begin
            chk("t6_no_write", rf_we_o, 0);
            tick();
        end
        chk("t6_rf10", rf_m[10], 0);
        chk("t6_rf11", rf_m[11], 0);
        chk("t6_rf12", rf_m[12], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
